// File: rtl/alu_issue_wb.sv
// ---------------------------------------------------------------------------
// alu_issue_wb
//
// Issue / write-back controller between RV32I fetch-decode and the ALU.
// Accepts one OP or OP-IMM instruction over a valid/ready handshake. It decodes
// the instruction into a 4-bit ALU opcode and operand B (imme_rs), and strobes
// op_valid for one cycle. It then waits for the ALU result and performs a
// single-cycle register-file write-back. Only one operation is in flight.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   instr_valid     instruction offered by decode
//   instr_ready     block is idle and can accept an instruction
//   instr           RV32I instruction word
//   rs1_addr        register-file read address (rs_data goes straight to ALU)
//   rs2_addr        register-file read address for rs2_data
//   rs2_data        register-file rs2 value (operand B for R-type)
//   opcode          ALU opcode {bit3, funct3}
//   imme_rs         ALU operand B
//   op_valid        one-cycle ALU start strobe
//   alu_data_out    ALU result
//   alu_data_valid  ALU result valid
//   rd_we           write-back enable (never asserted for x0)
//   rd_addr         write-back register
//   rd_data         write-back data
//   illegal_instr   one-cycle pulse when an offered instruction is rejected
//   alu_timeout     one-cycle pulse when the ALU fails to answer in MAX_WAIT
// ---------------------------------------------------------------------------
module alu_issue_wb #(
  parameter int BUS_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_WAIT     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [31:0]             instr,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [BUS_WIDTH-1:0]    rs2_data,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [BUS_WIDTH-1:0]    imme_rs,
  output logic                    op_valid,
  input  logic [BUS_WIDTH-1:0]    alu_data_out,
  input  logic                    alu_data_valid,
  output logic                    rd_we,
  output logic [4:0]              rd_addr,
  output logic [BUS_WIDTH-1:0]    rd_data,
  output logic                    illegal_instr,
  output logic                    alu_timeout
);

  // -------------------------------------------------------------------------
  // Configuration checks
  // -------------------------------------------------------------------------
  if (OPCODE_WIDTH != 4) begin : g_bad_opcode_width
    $error("alu_issue_wb: OPCODE_WIDTH must be 4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("alu_issue_wb: MAX_WAIT must be in 1..255");
  end
  if (BUS_WIDTH < 12) begin : g_bad_bus_width
    $error("alu_issue_wb: BUS_WIDTH must hold a 12-bit immediate");
  end

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Last count value of the WAIT counter; reaching it without a result
  // means MAX_WAIT WAIT cycles have elapsed.
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t               state;
  logic [4:0]           rd_q;
  logic                 is_r_q;     // operand B comes from rs2_data
  logic [BUS_WIDTH-1:0] imme_q;
  logic [7:0]           wait_cnt;

  // -------------------------------------------------------------------------
  // Instruction decode (pure function of the offered word)
  // -------------------------------------------------------------------------
  logic [6:0]           dec_major;
  logic [2:0]           dec_f3;
  logic [6:0]           dec_f7;
  logic                 dec_legal;
  logic                 dec_is_r;
  logic                 dec_bit3;
  logic [BUS_WIDTH-1:0] dec_imm;

  assign dec_major = instr[6:0];
  assign dec_f3    = instr[14:12];
  assign dec_f7    = instr[31:25];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    dec_legal = 1'b0;
    dec_is_r  = 1'b0;
    dec_bit3  = 1'b0;
    dec_imm   = '0;
    case (dec_major)
      OPC_OP: begin
        dec_is_r = 1'b1;
        // The alternate funct7 only exists for SUB and SRA.
        dec_legal = (dec_f7 == F7_ZERO) ||
                    ((dec_f7 == F7_ALT) && (dec_f3 == 3'b000 || dec_f3 == 3'b101));
        dec_bit3  = instr[30];
      end
      OPC_OP_IMM: begin
        case (dec_f3)
          3'b001: begin
            dec_legal = (dec_f7 == F7_ZERO);
            dec_imm   = {{(BUS_WIDTH-5){1'b0}}, instr[24:20]};
          end
          3'b101: begin
            dec_legal = (dec_f7 == F7_ZERO) || (dec_f7 == F7_ALT);
            dec_bit3  = instr[30];     // SRAI vs SRLI
            dec_imm   = {{(BUS_WIDTH-5){1'b0}}, instr[24:20]};
          end
          default: begin
            // instr[30] is an immediate bit here, not an opcode modifier.
            dec_legal = 1'b1;
            dec_imm   = {{(BUS_WIDTH-12){instr[31]}}, instr[31:20]};
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // During ISSUE an R-type operand B is forwarded from the register file so
  // the ALU sees it together with op_valid; it is captured at the end of
  // ISSUE and held from the register afterwards.
  assign imme_rs = (state == S_ISSUE && is_r_q) ? rs2_data : imme_q;

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      instr_ready   <= 1'b0;
      rs1_addr      <= '0;
      rs2_addr      <= '0;
      opcode        <= '0;
      op_valid      <= 1'b0;
      rd_we         <= 1'b0;
      rd_addr       <= '0;
      rd_data       <= '0;
      illegal_instr <= 1'b0;
      alu_timeout   <= 1'b0;
      rd_q          <= '0;
      is_r_q        <= 1'b0;
      imme_q        <= '0;
      wait_cnt      <= '0;
    end else begin
      // Single-cycle strobes default low.
      op_valid      <= 1'b0;
      rd_we         <= 1'b0;
      illegal_instr <= 1'b0;
      alu_timeout   <= 1'b0;

      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            if (dec_legal) begin
              rd_q        <= instr[11:7];
              rs1_addr    <= instr[19:15];
              rs2_addr    <= instr[24:20];
              opcode      <= {dec_bit3, dec_f3};
              is_r_q      <= dec_is_r;
              imme_q      <= dec_imm;
              op_valid    <= 1'b1;
              instr_ready <= 1'b0;
              state       <= S_ISSUE;
            end else begin
              illegal_instr <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (is_r_q) begin
            imme_q <= rs2_data;
          end
          wait_cnt <= '0;
          if (alu_data_valid) begin
            rd_we   <= (rd_q != 5'd0);
            rd_addr <= rd_q;
            rd_data <= alu_data_out;
            state   <= S_WB;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (alu_data_valid) begin
            rd_we   <= (rd_q != 5'd0);
            rd_addr <= rd_q;
            rd_data <= alu_data_out;
            state   <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            alu_timeout <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_WB: begin
          // The write-back cycle is spent even when rd is x0.
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: begin
          instr_ready <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_wb
//
// Directed bench for alu_issue_wb: a linear sequence of instructions with
// hand-computed opcodes, operands and write-back values. Inputs change 1 ns
// after each rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_alu_issue_wb;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [3:0]  opcode;
  logic [31:0] imme_rs;
  logic        op_valid;
  logic [31:0] alu_data_out;
  logic        alu_data_valid;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        illegal_instr;
  logic        alu_timeout;

  int total = 0;
  int bad   = 0;

  alu_issue_wb #(
    .BUS_WIDTH   (32),
    .OPCODE_WIDTH(4),
    .MAX_WAIT    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs2_data      (rs2_data),
    .opcode        (opcode),
    .imme_rs       (imme_rs),
    .op_valid      (op_valid),
    .alu_data_out  (alu_data_out),
    .alu_data_valid(alu_data_valid),
    .rd_we         (rd_we),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .illegal_instr (illegal_instr),
    .alu_timeout   (alu_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".instr_ready"},   32'(instr_ready),   32'h0);
    check({tag, ".rs1_addr"},      32'(rs1_addr),      32'h0);
    check({tag, ".rs2_addr"},      32'(rs2_addr),      32'h0);
    check({tag, ".opcode"},        32'(opcode),        32'h0);
    check({tag, ".imme_rs"},       imme_rs,            32'h0);
    check({tag, ".op_valid"},      32'(op_valid),      32'h0);
    check({tag, ".rd_we"},         32'(rd_we),         32'h0);
    check({tag, ".rd_addr"},       32'(rd_addr),       32'h0);
    check({tag, ".rd_data"},       rd_data,            32'h0);
    check({tag, ".illegal_instr"}, 32'(illegal_instr), 32'h0);
    check({tag, ".alu_timeout"},   32'(alu_timeout),   32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_valid    = 1'b0;
    instr          = 32'h0;
    rs2_data       = 32'h0;
    alu_data_out   = 32'h0;
    alu_data_valid = 1'b0;

    // ---- reset ----------------------------------------------------------
    #22;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset.instr_ready", 32'(instr_ready), 32'h1);

    // ---- ADDI x5,x1,-3 ; ALU answers in the ISSUE cycle -------------------
    instr       = 32'hFFD08293;
    instr_valid = 1'b1;
    tick();                                   // handshake edge
    instr_valid = 1'b0;
    check("addi.op_valid",    32'(op_valid),    32'h1);
    check("addi.opcode",      32'(opcode),      32'h0);
    check("addi.imme_rs",     imme_rs,          32'hFFFFFFFD);
    check("addi.rs1_addr",    32'(rs1_addr),    32'd1);
    check("addi.instr_ready", 32'(instr_ready), 32'h0);
    check("addi.rd_we_issue", 32'(rd_we),       32'h0);
    alu_data_valid = 1'b1;
    alu_data_out   = 32'h00000007;
    tick();                                   // WB, two cycles after handshake
    alu_data_valid = 1'b0;
    check("addi.rd_we",       32'(rd_we),       32'h1);
    check("addi.rd_addr",     32'(rd_addr),     32'd5);
    check("addi.rd_data",     rd_data,          32'h7);
    check("addi.op_valid_wb", 32'(op_valid),    32'h0);
    tick();
    check("addi.rd_we_after", 32'(rd_we),       32'h0);
    check("addi.ready_after", 32'(instr_ready), 32'h1);

    // ---- SUB x3,x1,x2 ; ALU answers in the 4th cycle after ISSUE ---------
    instr       = 32'h402081B3;
    rs2_data    = 32'h00000010;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("sub.op_valid", 32'(op_valid), 32'h1);
    check("sub.opcode",   32'(opcode),   32'h8);
    check("sub.imme_rs",  imme_rs,       32'h10);
    check("sub.rs1_addr", 32'(rs1_addr), 32'd1);
    check("sub.rs2_addr", 32'(rs2_addr), 32'd2);
    tick();
    rs2_data = 32'h00000099;                  // operand B must stay captured
    check("sub.op_valid_once", 32'(op_valid),    32'h0);
    check("sub.imme_held",     imme_rs,          32'h10);
    check("sub.opcode_held",   32'(opcode),      32'h8);
    check("sub.ready_wait1",   32'(instr_ready), 32'h0);
    tick();
    check("sub.ready_wait2", 32'(instr_ready), 32'h0);
    check("sub.rd_we_wait2", 32'(rd_we),       32'h0);
    tick();
    check("sub.ready_wait3", 32'(instr_ready), 32'h0);
    tick();
    alu_data_valid = 1'b1;
    alu_data_out   = 32'hFFFFFFF0;
    check("sub.rd_we_wait4", 32'(rd_we),       32'h0);
    check("sub.rs2_held",    32'(rs2_addr),    32'd2);
    tick();
    alu_data_valid = 1'b0;
    check("sub.rd_we",    32'(rd_we),       32'h1);
    check("sub.rd_addr",  32'(rd_addr),     32'd3);
    check("sub.rd_data",  rd_data,          32'hFFFFFFF0);
    check("sub.ready_wb", 32'(instr_ready), 32'h0);
    tick();
    check("sub.rd_we_once", 32'(rd_we),       32'h0);
    check("sub.ready_idle", 32'(instr_ready), 32'h1);

    // ---- SRAI x4,x4,31 ---------------------------------------------------
    instr       = 32'h41F25213;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("srai.op_valid", 32'(op_valid), 32'h1);
    check("srai.opcode",   32'(opcode),   32'hD);
    check("srai.imme_rs",  imme_rs,       32'h0000001F);
    alu_data_valid = 1'b1;
    alu_data_out   = 32'hFFFFFFFF;
    tick();
    alu_data_valid = 1'b0;
    check("srai.rd_we",   32'(rd_we),   32'h1);
    check("srai.rd_addr", 32'(rd_addr), 32'd4);
    tick();

    // ---- SLLI with funct7=0100000 : illegal ------------------------------
    instr       = 32'h41F21213;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("slli_bad.illegal",  32'(illegal_instr), 32'h1);
    check("slli_bad.op_valid", 32'(op_valid),      32'h0);
    check("slli_bad.ready",    32'(instr_ready),   32'h1);
    tick();
    check("slli_bad.pulse_end", 32'(illegal_instr), 32'h0);
    check("slli_bad.no_issue",  32'(op_valid),      32'h0);

    // ---- LW (unsupported major opcode) : illegal -------------------------
    instr       = 32'h0000A283;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("lw.illegal",  32'(illegal_instr), 32'h1);
    check("lw.op_valid", 32'(op_valid),      32'h0);
    tick();

    // ---- ADD x0,x1,x2 : write-back suppressed, cycle still spent ---------
    instr       = 32'h00208033;
    rs2_data    = 32'h00000005;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("add_x0.op_valid", 32'(op_valid), 32'h1);
    check("add_x0.opcode",   32'(opcode),   32'h0);
    check("add_x0.imme_rs",  imme_rs,       32'h5);
    alu_data_valid = 1'b1;
    alu_data_out   = 32'h00000042;
    tick();
    alu_data_valid = 1'b0;
    check("add_x0.rd_we_wb",  32'(rd_we),       32'h0);
    check("add_x0.ready_wb",  32'(instr_ready), 32'h0);
    tick();
    check("add_x0.rd_we_idle", 32'(rd_we),       32'h0);
    check("add_x0.ready_idle", 32'(instr_ready), 32'h1);

    // ---- ADD x7,x1,x2 with silent ALU : timeout after 16 WAIT cycles -----
    instr       = 32'h002083B3;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("tmo.op_valid", 32'(op_valid), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("tmo.wait%0d.timeout", i), 32'(alu_timeout), 32'h0);
      check($sformatf("tmo.wait%0d.ready", i),   32'(instr_ready), 32'h0);
    end
    tick();
    check("tmo.pulse", 32'(alu_timeout), 32'h1);
    check("tmo.ready", 32'(instr_ready), 32'h1);
    check("tmo.rd_we", 32'(rd_we),       32'h0);
    alu_data_valid = 1'b1;                    // late result must be ignored
    alu_data_out   = 32'h12345678;
    tick();
    check("tmo.pulse_end",  32'(alu_timeout), 32'h0);
    check("tmo.late_rd_we", 32'(rd_we),       32'h0);
    check("tmo.late_op",    32'(op_valid),    32'h0);
    tick();
    alu_data_valid = 1'b0;
    check("tmo.late_rd_we2", 32'(rd_we),       32'h0);
    check("tmo.late_ready",  32'(instr_ready), 32'h1);

    // ---- reset while in WAIT, then ORI x6,x0,0x0FF -----------------------
    instr       = 32'h402081B3;
    rs2_data    = 32'h00000010;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();                                   // now in WAIT
    check("rst_wait.before", 32'(instr_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_wait.ready", 32'(instr_ready), 32'h1);
    check("rst_wait.rd_we", 32'(rd_we),       32'h0);

    instr       = 32'h0FF06313;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("ori.op_valid", 32'(op_valid), 32'h1);
    check("ori.opcode",   32'(opcode),   32'h6);
    check("ori.imme_rs",  imme_rs,       32'h000000FF);
    check("ori.rs1_addr", 32'(rs1_addr), 32'd0);
    alu_data_valid = 1'b1;
    alu_data_out   = 32'h000000FF;
    tick();
    alu_data_valid = 1'b0;
    check("ori.rd_we",   32'(rd_we),   32'h1);
    check("ori.rd_addr", 32'(rd_addr), 32'd6);
    check("ori.rd_data", rd_data,      32'h000000FF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Sits between instruction fetch/decode and the ALU of the RV32I core.
- Accepts one OP/OP-IMM instruction at a time over a valid/ready handshake and decodes it into the ALU opcode and second operand (imme_rs).
- Drives register-file read addresses; the register file supplies rs_data to the ALU directly.
- Waits for alu_data_valid, then performs a one-cycle register-file write-back; only one operation is in flight at a time.

Parameters:
- BUS_WIDTH, 32, operand/result width.
- OPCODE_WIDTH, 4, ALU opcode width. Fixed at 4; any other value is a configuration error.
- MAX_WAIT, 16, maximum cycles in WAIT before timeout (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  32  RV32I instruction word.
- rs1_addr  out  5  register-file read address for rs_data.
- rs2_addr  out  5  register-file read address for rs2_data.
- rs2_data  in  BUS_WIDTH  register-file rs2 value.
- opcode  out  OPCODE_WIDTH  ALU opcode.
- imme_rs  out  BUS_WIDTH  ALU operand B.
- op_valid  out  1  one-cycle ALU start strobe.
- alu_data_out  in  BUS_WIDTH  ALU result.
- alu_data_valid  in  1  ALU result valid.
- rd_we  out  1  write-back enable.
- rd_addr  out  5  write-back register.
- rd_data  out  BUS_WIDTH  write-back data.
- illegal_instr  out  1  one-cycle pulse on a rejected instruction.
- alu_timeout  out  1  one-cycle pulse on ALU timeout.

Behaviour:
- **FSM states:** IDLE, ISSUE, WAIT, WB.
- **Reset:** all outputs 0, state IDLE. Reset asserted mid-operation abandons the operation with no write-back.
- **IDLE:**
  - instr_ready=1. Handshake occurs when instr_valid and instr_ready are both high at a rising edge.
  - Legal instruction: latch rd=instr[11:7], rs1_addr=instr[19:15], rs2_addr=instr[24:20], compute opcode, go to ISSUE.
  - Illegal instruction: pulse illegal_instr the next cycle, stay in IDLE.
- **Legal instructions:**
  - instr[6:0]=0110011 (R-type), funct7 in {0000000, 0100000}; 0100000 is legal only with funct3 000 or 101.
  - instr[6:0]=0010011 (I-type); for funct3=001, funct7 must be 0000000; for funct3=101, funct7 must be in {0000000, 0100000}.
- **Opcode encoding:** {bit3, funct3}.
  - bit3 = instr[30] for R-type SUB/SRA and for I-type SRAI; otherwise 0.
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- **Operand B (imme_rs):**
  - R-type: rs2_data sampled in ISSUE.
  - I-type shifts: zero-extended instr[24:20].
  - Other I-type: sign-extended instr[31:20].
  - rs1_addr/rs2_addr are held stable from ISSUE through WB.
- **ISSUE:** op_valid=1 for exactly one cycle, with opcode and imme_rs valid. Go to WAIT, or straight to WB if alu_data_valid=1 in this cycle.
- **WAIT:**
  - opcode and imme_rs are held.
  - alu_data_valid=1: capture alu_data_out, go to WB.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT, pulse alu_timeout, go to IDLE, no write-back.
- **WB:**
  - rd_we=1 for one cycle with rd_addr=rd and rd_data=captured result.
  - rd_we is suppressed when rd=0; the cycle is still spent.
  - Next state IDLE.
- **Other boundary rules:**
  - alu_data_valid in IDLE or WB is ignored.
  - instr_ready=0 in ISSUE, WAIT and WB; there is no back-to-back acceptance.
- **Latency:** handshake edge → op_valid next cycle → earliest rd_we 2 cycles after handshake.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), ALU returns 0x00000007 in the ISSUE cycle → opcode=0000, imme_rs=0xFFFFFFFD, op_valid 1 cycle, rd_we=1 with rd_addr=5, rd_data=7 two cycles after the handshake.
- SUB x3,x1,x2 (0x402081B3) with rs2_data=0x10, ALU valid 4 cycles after ISSUE → opcode=1000, imme_rs=0x10, rd_we once with rd_data = ALU value, instr_ready low throughout.
- SRAI x4,x4,31 (0x41F25213) → opcode=1101, imme_rs=0x0000001F. Repeat with funct7=0100000 on SLLI → illegal_instr pulse, no op_valid.
- ADD x0,x1,x2 → op_valid pulses, ALU result returns, rd_we stays 0, FSM returns to IDLE.
- ALU never asserts valid with MAX_WAIT=16 → alu_timeout pulses after 16 WAIT cycles, no rd_we, instr_ready=1 on the next cycle. A late alu_data_valid afterwards is ignored.
- Assert rst_n=0 while in WAIT → all outputs 0 immediately and state IDLE. A following ORI x6,x0,0x0FF gives opcode=0110, imme_rs=0x000000FF.
